key_encoder: RTL and testbench



---
 rtl/key_encoder_pkg.sv | 34 +++
 rtl/key_debounce.sv | 61 ++++++
 rtl/key_encoder.sv | 141 ++++++++++++++
 tb/tb_key_encoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_encoder_pkg.sv
// key_encoder_pkg: shared widths, FSM state type and the priority encoder for
// the active-low key encoder.
//   KEY_W    number of key lines
//   CODE_W   width of the encoded {A,B} code
//   state_e  IDLE / REPORT / RELEASE
//   prio_enc highest-index active-low key wins (bit3 -> 2'b11 ... bit0 -> 2'b00)
package key_encoder_pkg;

  localparam int unsigned KEY_W  = 4;
  localparam int unsigned CODE_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REPORT  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Returns the code of the highest-index key that is low. An all-high
  // vector also yields 2'b00; callers qualify with "any key pressed".
  function automatic logic [CODE_W-1:0] prio_enc(input logic [KEY_W-1:0] active_low);
    logic [CODE_W-1:0] code;
    if (!active_low[3]) begin
      code = 2'b11;
    end else if (!active_low[2]) begin
      code = 2'b10;
    end else if (!active_low[1]) begin
      code = 2'b01;
    end else begin
      code = 2'b00;
    end
    return code;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchronizer, stability counter and debounced vector
// for the four active-low key lines.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   key_n  raw active-low keys, asynchronous to clk
//   deb_n  debounced active-low key vector (registered)
// A new value reaches deb_n once the synchronized vector has been identical
// for DEBOUNCE_CYCLES consecutive samples.
module key_debounce
  import key_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_n,
  output logic [KEY_W-1:0] deb_n
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_W-1:0] sync1_q, sync2_q;
  logic [KEY_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable;

  // Stability counter: clears on any change between consecutive synced
  // samples, saturates at CNT_MAX; the vector loads on the edge the counter
  // reaches (or sits at) CNT_MAX.
  always_comb begin
    stable = (sync1_q == sync2_q);
    cnt_d  = '0;
    deb_d  = deb_q;
    if (stable) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
    if (stable && (cnt_d == CNT_MAX)) begin
      deb_d = sync2_q;
    end
  end

  // Synchronizer, counter and debounced vector registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      cnt_q   <= '0;
      deb_q   <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  assign deb_n = deb_q;

endmodule

// File: rtl/key_encoder.sv
// key_encoder: debounces four active-low keys and presents each press as a
// registered 2-bit code {A,B} with a valid/ack handshake.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   key_n  raw active-low keys; bit i pressed = code i
//   ack    consumer accepts the current code
//   A, B   code MSB / LSB (registered)
//   valid  code on A/B is a new, unconsumed press (registered)
//   none   debounced vector is all released (registered)
// Build option: define KEY_REPEAT_EN to enable auto-repeat while the same key
// keeps priority (period set by REPEAT_CYCLES).
module key_encoder
  import key_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
`ifdef KEY_REPEAT_EN
  , parameter int unsigned REPEAT_CYCLES = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_n,
  input  logic             ack,
  output logic             A,
  output logic             B,
  output logic             valid,
  output logic             none
);

  logic [KEY_W-1:0]  deb_n;
  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              none_q, none_d;
  logic              any_pressed;

`ifdef KEY_REPEAT_EN
  localparam int unsigned      REP_W   = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .deb_n (deb_n)
  );

  assign any_pressed = ~(&deb_n);

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    none_d  = &deb_n;
`ifdef KEY_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_pressed) begin
          code_d  = prio_enc(deb_n);
          valid_d = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        // Releasing keys here does not cancel the event; only ack ends it.
        if (ack) begin
          valid_d = 1'b0;
          state_d = RELEASE;
`ifdef KEY_REPEAT_EN
          rep_d   = '0;
`endif
        end
      end
      RELEASE: begin
`ifdef KEY_REPEAT_EN
        if (none_q) begin
          state_d = IDLE;
          rep_d   = '0;
        end else if (any_pressed && (prio_enc(deb_n) == code_q)) begin
          if (rep_q == REP_MAX) begin
            valid_d = 1'b1;
            state_d = REPORT;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end else begin
          rep_d = '0;
        end
`else
        // Other keys pressed while one is still held never raise an event.
        if (none_q) begin
          state_d = IDLE;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
      none_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      none_q  <= none_d;
    end
  end

`ifdef KEY_REPEAT_EN
  // Auto-repeat hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  assign A     = code_q[1];
  assign B     = code_q[0];
  assign valid = valid_q;
  assign none  = none_q;

endmodule

// File: tb/tb_key_encoder.sv
// tb_key_encoder: directed and random stimulus for key_encoder, checked every
// cycle against a behavioural model plus directed constant expectations.
module tb_key_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ack;
  logic [3:0] key_n;
  logic       A, B, valid, none;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [3:0] m_deb;
  logic       m_none;
  logic       m_valid;
  logic [1:0] m_code;
  int         m_phase;      // 0 waiting for press, 1 reporting, 2 waiting for release
  logic [3:0] hist[$];      // most recent key_n samples, oldest first

  always #5 clk = ~clk;

  key_encoder #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .ack   (ack),
    .A     (A),
    .B     (B),
    .valid (valid),
    .none  (none)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Highest-index pressed key.
  function automatic logic [1:0] top_pressed(input logic [3:0] k);
    logic [1:0] c;
    c = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!k[i]) c = 2'(i);
    end
    return c;
  endfunction

  // One clock of the model. The debounced vector takes a value once the
  // last D samples taken before this edge all agree.
  task automatic model_edge(input logic r, input logic [3:0] k, input logic a);
    logic [3:0] deb_old;
    logic       none_old;
    bit         same;
    deb_old  = m_deb;
    none_old = m_none;
    if (r) begin
      m_deb   = 4'hF;
      m_none  = 1'b1;
      m_valid = 1'b0;
      m_code  = 2'd0;
      m_phase = 0;
      hist.delete();
      return;
    end
    if (hist.size() >= D) begin
      same = 1'b1;
      for (int i = 1; i < D; i++) begin
        if (hist[i] != hist[0]) same = 1'b0;
      end
      if (same) m_deb = hist[0];
    end
    hist.push_back(k);
    if (hist.size() > D) void'(hist.pop_front());
    m_none = &deb_old;
    case (m_phase)
      0: if (deb_old != 4'hF) begin
           m_code  = top_pressed(deb_old);
           m_valid = 1'b1;
           m_phase = 1;
         end
      1: if (a) begin
           m_valid = 1'b0;
           m_phase = 2;
         end
      default: if (none_old) m_phase = 0;
    endcase
  endtask

  task automatic step(input logic r, input logic [3:0] k, input logic a);
    @(negedge clk);
    reset = r;
    key_n = k;
    ack   = a;
    @(posedge clk);
    model_edge(r, k, a);
    #1;
    chk("model_valid", 4'(valid), 4'(m_valid));
    chk("model_code", 4'({A, B}), 4'(m_code));
    chk("model_none", 4'(none), 4'(m_none));
  endtask

  initial begin
    logic [3:0] rk;
    int         hold;
    int         events;
    logic       vprev;

    reset = 1'b1;
    key_n = 4'h0;
    ack   = 1'b0;

    // Reset held with all keys pressed.
    repeat (3) step(1'b1, 4'h0, 1'b0);
    chk("rst_valid", 4'(valid), 4'h0);
    chk("rst_code", 4'({A, B}), 4'h0);
    chk("rst_none", 4'(none), 4'h1);

    // First event appears 2+D clocks after reset is released.
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 4'h0, 1'b0);
      if (i == 5) chk("rst_lat5_valid", 4'(valid), 4'h0);
    end
    chk("rst_lat6_valid", 4'(valid), 4'h1);
    chk("rst_lat6_code", 4'({A, B}), 4'h3);
    step(1'b0, 4'h0, 1'b1);
    chk("rst_ack_valid", 4'(valid), 4'h0);
    repeat (12) step(1'b0, 4'hF, 1'b0);

    // ack without a pending code is ignored.
    repeat (4) step(1'b0, 4'hF, 1'b1);
    chk("idle_ack_valid", 4'(valid), 4'h0);

    // Key 1: latency, hold without ack, ack clears next edge.
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 4'b1101, 1'b0);
      if (i == 5) chk("k1_lat5_valid", 4'(valid), 4'h0);
    end
    chk("k1_lat6_valid", 4'(valid), 4'h1);
    chk("k1_lat6_code", 4'({A, B}), 4'h1);
    repeat (10) begin
      step(1'b0, 4'b1101, 1'b0);
      chk("k1_hold_valid", 4'(valid), 4'h1);
      chk("k1_hold_code", 4'({A, B}), 4'h1);
    end
    step(1'b0, 4'b1101, 1'b1);
    chk("k1_ack_valid", 4'(valid), 4'h0);
    repeat (12) step(1'b0, 4'hF, 1'b0);

    // Keys 3+0, then add key 2 while held, then key 2 alone.
    repeat (6) step(1'b0, 4'b0110, 1'b0);
    chk("k30_code", 4'({A, B}), 4'h3);
    step(1'b0, 4'b0110, 1'b1);
    repeat (15) begin
      step(1'b0, 4'b0010, 1'b0);
      chk("k2_held_novalid", 4'(valid), 4'h0);
    end
    repeat (12) step(1'b0, 4'hF, 1'b0);
    repeat (6) step(1'b0, 4'b1011, 1'b0);
    chk("k2_valid", 4'(valid), 4'h1);
    chk("k2_code", 4'({A, B}), 4'h2);
    step(1'b0, 4'b1011, 1'b1);
    repeat (12) step(1'b0, 4'hF, 1'b0);

    // Glitch of D-1 clocks is filtered.
    repeat (3) step(1'b0, 4'b1101, 1'b0);
    repeat (12) begin
      step(1'b0, 4'hF, 1'b0);
      chk("glitch_valid", 4'(valid), 4'h0);
      chk("glitch_none", 4'(none), 4'h1);
    end

    // Pulse of exactly D clocks produces one event.
    events = 0;
    vprev  = valid;
    repeat (4) begin
      step(1'b0, 4'b1101, 1'b0);
      if (valid && !vprev) events++;
      vprev = valid;
    end
    repeat (12) begin
      step(1'b0, 4'hF, 1'b0);
      if (valid && !vprev) events++;
      vprev = valid;
    end
    chk("pulse_events", 4'(events), 4'h1);
    chk("pulse_code", 4'({A, B}), 4'h1);
    step(1'b0, 4'hF, 1'b1);
    repeat (4) step(1'b0, 4'hF, 1'b0);

    // Key 0 released before ack: event survives, next press accepted.
    repeat (6) step(1'b0, 4'b1110, 1'b0);
    chk("k0_valid", 4'(valid), 4'h1);
    repeat (10) begin
      step(1'b0, 4'hF, 1'b0);
      chk("k0_rel_valid", 4'(valid), 4'h1);
      chk("k0_rel_code", 4'({A, B}), 4'h0);
    end
    step(1'b0, 4'hF, 1'b1);
    chk("k0_ack_valid", 4'(valid), 4'h0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 4'b1101, 1'b0);
      if (i == 5) chk("next_lat5_valid", 4'(valid), 4'h0);
    end
    chk("next_valid", 4'(valid), 4'h1);
    chk("next_code", 4'({A, B}), 4'h1);
    step(1'b0, 4'b1101, 1'b1);
    repeat (12) step(1'b0, 4'hF, 1'b0);

    // Random keys, holds, acks and occasional resets against the model.
    hold = 0;
    rk   = 4'hF;
    for (int n = 0; n < 700; n++) begin
      if (hold == 0) begin
        rk   = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
        hold = $urandom_range(1, 10);
      end
      hold--;
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, rk,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
